// File: rtl/gato_pkg.sv
// gato_pkg: shared cell/state types, board size and the eight winning lines
package gato_pkg;
  typedef enum logic [1:0] {VACIO = 2'b00, X = 2'b01, O = 2'b10} cell_t;
  typedef enum logic [2:0] {PLAY, WRITE, EVAL, OVER, CLR} state_t;
  localparam int N_CELLS = 9;
  localparam logic [3:0] LINES [8][3] = '{
    '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
  };
  function automatic logic [3:0] firstEmpty(input logic [N_CELLS-1:0][1:0] b);
    firstEmpty = 4'd0;
    for (int i = N_CELLS - 1; i >= 0; i--) if (b[i] == VACIO) firstEmpty = 4'(i);
  endfunction
endpackage

// File: rtl/gato_resultado.sv
// gato_resultado: combinational win/winner/full evaluation of the board
module gato_resultado
  import gato_pkg::*;
(
  input  logic [N_CELLS-1:0][1:0] board,
  output logic                    win,
  output logic [1:0]              winner,
  output logic                    full
);
  logic [8:0][1:0] pick;
  logic [N_CELLS-1:0] occ;
  assign pick[0] = VACIO;
  // first winning line in table order supplies the symbol
  for (genvar g = 0; g < 8; g++) begin : gLine
    logic [1:0] a, b, c;
    assign a = board[LINES[g][0]];
    assign b = board[LINES[g][1]];
    assign c = board[LINES[g][2]];
    assign pick[g+1] = pick[g] != VACIO ? pick[g] : (a != VACIO && a == b && b == c) ? a : VACIO;
  end
  for (genvar g = 0; g < N_CELLS; g++) begin : gCell
    assign occ[g] = board[g] != VACIO;
  end
  assign win = pick[8] != VACIO;
  assign winner = pick[8];
  assign full = &occ;
endmodule

// File: rtl/gato_controller.sv
// gato_controller: tic-tac-toe turn/cursor/timer/outcome sequencer
// GATO_AUTOPLACE_EN: a timeout places the current symbol on the lowest empty cell
module gato_controller
  import gato_pkg::*;
#(
  parameter int TURN_CYCLES = 500_000_000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           mover,
  input  logic                           colocar,
  input  logic [8:0][1:0]                board,
  output logic                           wr_en,
  output logic [3:0]                     wr_addr,
  output logic [1:0]                     wr_sym,
  output logic                           board_clr,
  output logic [3:0]                     cursor,
  output logic                           jugador,
  output logic [$clog2(TURN_CYCLES)-1:0] time_left,
  output logic                           timeout,
  output logic                           rechazo,
  output logic                           win,
  output logic [1:0]                     winner,
  output logic                           draw,
  output logic                           game_over
);
  localparam int TW = $clog2(TURN_CYCLES);
  localparam logic [TW-1:0] RELOAD = TW'(TURN_CYCLES - 1);
  state_t state, stateN;
  logic [3:0] cursorN, addr, addrN;
  logic [1:0] winnerN, evWinner;
  logic [TW-1:0] timeN;
  logic jugadorN, timeoutN, rechazoN, winN, drawN, evWin, evFull, cellFree;
  gato_resultado uRes (.board(board), .win(evWin), .winner(evWinner), .full(evFull));
  assign cellFree = board[cursor] == VACIO;
  assign wr_en = state == WRITE;
  assign wr_addr = addr;
  assign wr_sym = jugador ? X : O;
  assign board_clr = state == CLR;
  assign game_over = win | draw;
  always_ff @(posedge clk)
    if (rst) begin
      state <= PLAY;
      cursor <= 4'd0;
      jugador <= 1'b1;
      time_left <= RELOAD;
      addr <= 4'd0;
      timeout <= 1'b0;
      rechazo <= 1'b0;
      win <= 1'b0;
      winner <= 2'b00;
      draw <= 1'b0;
    end else begin
      state <= stateN;
      cursor <= cursorN;
      jugador <= jugadorN;
      time_left <= timeN;
      addr <= addrN;
      timeout <= timeoutN;
      rechazo <= rechazoN;
      win <= winN;
      winner <= winnerN;
      draw <= drawN;
    end
  always_comb begin
    stateN = state;
    cursorN = cursor;
    jugadorN = jugador;
    timeN = time_left;
    addrN = addr;
    winN = win;
    winnerN = winner;
    drawN = draw;
    timeoutN = 1'b0;
    rechazoN = 1'b0;
    case (state)
      PLAY: begin
        if (colocar && cellFree) begin
          stateN = WRITE;
          addrN = cursor;
        end else begin
          rechazoN = colocar;
          cursorN = (mover && !colocar) ? (cursor == 4'd8 ? 4'd0 : cursor + 4'd1) : cursor;
          timeN = time_left - 1'b1;
          // only an accepted placement pre-empts the expiry
          if (time_left == '0) begin
            timeoutN = 1'b1;
`ifdef GATO_AUTOPLACE_EN
            stateN = WRITE;
            addrN = firstEmpty(board);
            timeN = time_left;
`else
            jugadorN = !jugador;
            timeN = RELOAD;
`endif
          end
        end
      end
      WRITE: stateN = EVAL;
      EVAL: begin
        if (evWin) begin
          winN = 1'b1;
          winnerN = evWinner;
          stateN = OVER;
        end else if (evFull) begin
          drawN = 1'b1;
          stateN = OVER;
        end else begin
          jugadorN = !jugador;
          timeN = RELOAD;
          stateN = PLAY;
        end
      end
      OVER: stateN = colocar ? CLR : OVER;
      CLR: begin
        winN = 1'b0;
        winnerN = 2'b00;
        drawN = 1'b0;
        cursorN = 4'd0;
        jugadorN = 1'b1;
        timeN = RELOAD;
        stateN = PLAY;
      end
      default: stateN = PLAY;
    endcase
  end
endmodule

// File: tb/tb_gato_controller.sv
// tb_gato_controller: directed game scenarios plus random play against a rule-level game model
module tb_gato_controller;
  localparam int TC = 20;
  logic clk = 1'b0, rst = 1'b1, mover = 1'b0, colocar = 1'b0;
  logic [8:0][1:0] boardMem;
  logic wr_en, board_clr, jugador, timeout, rechazo, win, draw, game_over;
  logic [3:0] wr_addr, cursor;
  logic [1:0] wr_sym, winner;
  logic [$clog2(TC)-1:0] time_left;
  int checks = 0, errors = 0;
  int mBoard [9];
  int mCur, mPl, mTime, mWrAddr, mWrSym, mWinner, w;
  bit mTo, mRej, mWin, mDraw, mWr, mClr, pendEval, over, started;
  int LN [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  always #5 clk = ~clk;

  gato_controller #(.TURN_CYCLES(TC)) dut (
    .clk(clk), .rst(rst), .mover(mover), .colocar(colocar), .board(boardMem),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_sym(wr_sym), .board_clr(board_clr),
    .cursor(cursor), .jugador(jugador), .time_left(time_left), .timeout(timeout),
    .rechazo(rechazo), .win(win), .winner(winner), .draw(draw), .game_over(game_over)
  );

  // board storage: commits a write one cycle after wr_en, cleared by reset or board_clr
  always @(posedge clk)
    if (rst || board_clr) boardMem <= '0;
    else if (wr_en) boardMem[wr_addr] <= wr_sym;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  function automatic int lineWinner();
    for (int l = 0; l < 8; l++)
      if (mBoard[LN[l][0]] != 0 && mBoard[LN[l][0]] == mBoard[LN[l][1]] && mBoard[LN[l][1]] == mBoard[LN[l][2]])
        return mBoard[LN[l][0]];
    return 0;
  endfunction

  function automatic bit boardFull();
    foreach (mBoard[i]) if (mBoard[i] == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int lowestEmpty();
    foreach (mBoard[i]) if (mBoard[i] == 0) return i;
    return 0;
  endfunction

  // game model: one update per clock edge from the rules of play
  always @(posedge clk) begin
    started = 1'b1;
    mTo = 1'b0;
    mRej = 1'b0;
    if (rst) begin
      foreach (mBoard[i]) mBoard[i] = 0;
      mCur = 0; mPl = 1; mTime = TC - 1; mWin = 0; mWinner = 0; mDraw = 0;
      mWr = 0; mClr = 0; pendEval = 0; over = 0; mWrAddr = 0; mWrSym = 0;
    end else if (mWr) begin
      mBoard[mWrAddr] = mWrSym;
      mWr = 0;
      pendEval = 1;
    end else if (pendEval) begin
      pendEval = 0;
      w = lineWinner();
      if (w != 0) begin mWin = 1; mWinner = w; over = 1; end
      else if (boardFull()) begin mDraw = 1; over = 1; end
      else begin mPl = 1 - mPl; mTime = TC - 1; end
    end else if (mClr) begin
      foreach (mBoard[i]) mBoard[i] = 0;
      mClr = 0; over = 0; mWin = 0; mWinner = 0; mDraw = 0; mCur = 0; mPl = 1; mTime = TC - 1;
    end else if (over) begin
      mClr = colocar;
    end else if (colocar && mBoard[mCur] == 0) begin
      mWr = 1; mWrAddr = mCur; mWrSym = mPl ? 1 : 2;
    end else begin
      mRej = colocar;
      if (mover && !colocar) mCur = (mCur + 1) % 9;
      if (mTime == 0) begin
        mTo = 1;
`ifdef GATO_AUTOPLACE_EN
        mWr = 1; mWrAddr = lowestEmpty(); mWrSym = mPl ? 1 : 2;
`else
        mPl = 1 - mPl; mTime = TC - 1;
`endif
      end else mTime--;
    end
  end

  always @(negedge clk)
    if (started) begin
      chk("cursor", cursor, mCur);
      chk("jugador", jugador, mPl);
      chk("time_left", time_left, mTime);
      chk("timeout", timeout, mTo);
      chk("rechazo", rechazo, mRej);
      chk("win", win, mWin);
      chk("winner", winner, mWinner);
      chk("draw", draw, mDraw);
      chk("game_over", game_over, mWin | mDraw);
      chk("wr_en", wr_en, mWr);
      chk("board_clr", board_clr, mClr);
      if (mWr) begin
        chk("wr_addr", wr_addr, mWrAddr);
        chk("wr_sym", wr_sym, mWrSym);
      end
    end

  task automatic step(input logic m, input logic c);
    mover = m;
    colocar = c;
    @(negedge clk);
    mover = 1'b0;
    colocar = 1'b0;
  endtask

  task automatic place(input int idx);
    for (int n = 0; n < 9 && cursor != idx; n++) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    step(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    step(1'b0, 1'b0);
    doReset();
    chk("rst cursor", cursor, 0);
    chk("rst jugador", jugador, 1);
    chk("rst time_left", time_left, 19);
    chk("rst wr_en", wr_en, 0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0);
      chk("mover cursor", cursor, (i + 1) % 9);
    end
    chk("mover jugador", jugador, 1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    chk("place wr_en", wr_en, 1);
    chk("place wr_addr", wr_addr, 4);
    chk("place wr_sym", wr_sym, 1);
    step(1'b0, 1'b0);
    chk("eval wr_en", wr_en, 0);
    step(1'b0, 1'b0);
    chk("turn jugador", jugador, 0);
    step(1'b0, 1'b1);
    chk("occupied rechazo", rechazo, 1);
    chk("occupied wr_en", wr_en, 0);
    step(1'b0, 1'b0);
    chk("rechazo pulse", rechazo, 0);

    doReset();
    place(0); place(3); place(1); place(4); place(2);
    chk("row win", win, 1);
    chk("row winner", winner, 1);
    chk("row game_over", game_over, 1);
    step(1'b1, 1'b0);
    chk("over cursor", cursor, 2);
    step(1'b0, 1'b1);
    chk("new game clr", board_clr, 1);
    step(1'b0, 1'b0);
    chk("new game jugador", jugador, 1);
    chk("new game win", win, 0);

    place(0); place(1); place(2); place(4); place(3);
    place(5); place(7); place(6); place(8);
    chk("draw", draw, 1);
    chk("draw win", win, 0);
    step(1'b0, 1'b1);
    chk("draw clr", board_clr, 1);
    step(1'b0, 1'b0);
    chk("draw clr jugador", jugador, 1);
    chk("draw cleared", draw, 0);

    place(0); place(1);
    for (int i = 0; i < 19; i++) step(1'b0, 1'b0);
    chk("pre-expiry time", time_left, 0);
    chk("pre-expiry timeout", timeout, 0);
    step(1'b0, 1'b0);
    chk("timeout pulse", timeout, 1);
`ifdef GATO_AUTOPLACE_EN
    chk("autoplace wr_en", wr_en, 1);
    chk("autoplace wr_addr", wr_addr, 2);
    chk("autoplace wr_sym", wr_sym, 1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("autoplace jugador", jugador, 0);
`else
    chk("timeout jugador", jugador, 0);
    chk("timeout wr_en", wr_en, 0);
    chk("timeout reload", time_left, 19);
`endif

    doReset();
    step(1'b0, 1'b1);
    chk("write before rst", wr_en, 1);
    rst = 1'b1;
    step(1'b0, 1'b0);
    rst = 1'b0;
    chk("rst-in-write wr_en", wr_en, 0);
    chk("rst-in-write cursor", cursor, 0);
    chk("rst-in-write jugador", jugador, 1);
    chk("rst-in-write time", time_left, 19);
    chk("rst-in-write board", boardMem, 0);

    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 299) == 0;
      mover = $urandom_range(0, 3) == 0;
      colocar = $urandom_range(0, 5) == 0;
      @(negedge clk);
    end
    rst = 1'b0;
    mover = 1'b0;
    colocar = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gato_controller.md
# gato_controller

Game sequencer for the tic-tac-toe board. It owns the turn, the cursor, the per-turn timer and the game outcome. It drives single-cycle write commands into the board storage and evaluates win/draw from the board read back. It sits between the debounced `mover`/`colocar` buttons and the board storage, replacing free-running turn/timer/win logic with one FSM.

## Interface
- `TURN_CYCLES`, default 500_000_000: clock cycles allowed per turn (10 s at 50 MHz); must be ≥ 2.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high; all state returns to reset values on the next `clk` edge.
- `mover`  in  1  one-cycle pulse: advance cursor.
- `colocar`  in  1  one-cycle pulse: place symbol at cursor / start new game when over.
- `board`  in  [8:0][1:0]  current board from storage; cell 00 empty, 01 X, 10 O; 11 never written.
- `wr_en`  out  1  board write strobe, one cycle.
- `wr_addr`  out  4  cell index 0–8 for the write.
- `wr_sym`  out  2  symbol to write (01/10).
- `board_clr`  out  1  one-cycle board clear.
- `cursor`  out  4  selected cell 0–8.
- `jugador`  out  1  player to move (1 X, 0 O).
- `time_left`  out  $clog2(TURN_CYCLES)  cycles remaining in turn.
- `timeout`  out  1  one-cycle pulse when turn timer expires.
- `rechazo`  out  1  one-cycle pulse: placement on occupied cell refused.
- `win`  out  1  game won.
- `winner`  out  2  winning symbol, 00 if none.
- `draw`  out  1  board full, no winner.
- `game_over`  out  1  `win | draw`.

## Operation
- Reset values: state PLAY, `cursor`=0, `jugador`=1, `time_left`=TURN_CYCLES-1, all other outputs 0.
- FSM states: PLAY, WRITE, EVAL, OVER, CLR.
- PLAY:
  - Timer decrements once per cycle.
  - `mover` sets `cursor` to `cursor`+1, wrapping 8→0.
  - `colocar` with `board[cursor]`==00 → WRITE. With the cell occupied: pulse `rechazo`, stay in PLAY, timer keeps running.
  - `mover` and `colocar` in the same cycle: `colocar` wins, cursor unchanged.
  - `time_left`==0 without `colocar`: pulse `timeout`, toggle `jugador`, reload timer to TURN_CYCLES-1, stay in PLAY.
  - `colocar` on the expiry cycle takes priority over the timeout.
- WRITE:
  - `wr_en`=1, `wr_addr`=latched index, `wr_sym`=01 if `jugador` else 10.
  - Storage commits at the end of this cycle. Next state EVAL.
- EVAL:
  - Evaluate the 8 lines (rows 012/345/678, columns 036/147/258, diagonals 048/246). A line wins when all three cells are equal and ≠00.
  - Any winning line: `win`=1, `winner`=that symbol → OVER.
  - Else, all 9 cells ≠00: `draw`=1 → OVER.
  - Else: toggle `jugador`, reload timer → PLAY.
- OVER: timer frozen, `mover` ignored, results held. `colocar` → CLR.
- CLR: `board_clr`=1; clear `win`/`winner`/`draw`; `cursor`=0, `jugador`=1, reload timer → PLAY.
- `mover`/`colocar` are ignored in WRITE, EVAL and CLR.
- `rst` in any state, including WRITE, aborts the operation; no write is issued on the reset cycle.

## Timing
- All outputs are registered or decoded from the state register; there is no combinational input→output path.
- `colocar` sampled at edge k → `wr_en` high in cycle k+1 → EVAL in k+2 → `win`/`draw` or toggled `jugador` visible from k+3.
- `rechazo`/`timeout` assert the cycle after the sampling edge, for one cycle.
- The timer is exactly TURN_CYCLES cycles from reload to the `timeout` pulse.
- `board` must reflect a write one cycle after `wr_en`.

## Configuration
- `GATO_AUTOPLACE_EN` defined: on timeout, instead of passing the turn, the controller enters WRITE with `wr_addr` = lowest-index empty cell and the current player's symbol. The `timeout` pulse still fires. An empty cell always exists in PLAY.
- Undefined: timeout passes the turn as described above.

## Structure
- `gato_pkg`:
  - `cell_t` enum (VACIO=00, X=01, O=10).
  - `state_t` enum.
  - `N_CELLS`=9.
  - `LINES` constant array [8][3] of cell indices.
- Sub-module `gato_resultado`: combinational; inputs `board`; outputs `win`, `winner`, `full`. Instantiated once and sampled in EVAL.

## Test plan
All scenarios use TURN_CYCLES=20.
- Reset, then 10 `mover` pulses → `cursor` steps 1..8, 0, 1; `jugador`=1; `time_left`=19 after reset.
- `colocar` at cursor 4 → `wr_en` one cycle with `wr_addr`=4, `wr_sym`=01; `jugador`=0 three cycles after `colocar`. Second `colocar` at 4 → `rechazo` pulse, no `wr_en`.
- X plays 0, 1, 2 against O plays 3, 4 → `win`=1, `winner`=01, `game_over`=1. Further `mover` leaves `cursor` unchanged.
- Sequence X0 O1 X2 O4 X3 O5 X7 O6 X8 → `draw`=1, `win`=0. Then `colocar` → `board_clr` one cycle and return to PLAY with `jugador`=1.
- Idle for 20 cycles → `timeout` pulse, `jugador` toggles, no `wr_en`. With `GATO_AUTOPLACE_EN` and cells 0, 1 full: `wr_addr`=2.
- Assert `rst` during WRITE → no `wr_en` on the following cycle; all outputs at reset values.
